// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the multi-digit BCD timer.
// Holds the FSM state encoding, the digit width and the BCD validity check.
package bcd_timer_pkg;

    localparam int        BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit: sync reset > load > enabled step, wraps 9<->0.
// Output updates one cycle after en/load; at_limit is combinational on up.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             at_limit_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                digit_d = (digit_q >= BCD_MAX) ? '0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o    = digit_q;
    assign at_limit_o = up_i ? (digit_q == BCD_MAX) : (digit_q == '0);

endmodule

// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with run/pause/done FSM, optional auto-reload.
// Outputs registered (1-cycle latency) except tc, which is combinational in the tick cycle.
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] data,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    tick,
    input  logic                    up,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    tc,
    output logic                    err
);

    state_t                  state_q;
    logic                    running_q;
    logic                    done_q;
    logic                    err_q;
    logic [BCD_W*DIGITS-1:0] reload_q;

    logic                    data_ok;
    logic [BCD_W*DIGITS-1:0] load_data;
    logic [BCD_W*DIGITS-1:0] dig_val;
    logic                    dig_load;
    logic                    act_tick;
    logic                    step_en;
    logic                    restart;
    logic [DIGITS-1:0]       at_lim;
    logic [DIGITS:0]         lim_chain;

    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(data[i*BCD_W +: BCD_W])) data_ok = 1'b0;
        end
    end

    assign load_data = data_ok ? data : '0;

    // A tick only acts in RUN when neither load nor stop claims the cycle;
    // start in RUN is ignored, so it does not block the tick.
    assign act_tick = (state_q == RUN) && tick && !load && !stop;
    assign step_en  = act_tick && !tc;
    assign restart  = start && !load && !stop && (state_q == DONE);
    assign dig_load = load || restart || (act_tick && tc && AUTO_RELOAD);
    assign dig_val  = load ? load_data : reload_q;

    assign lim_chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign lim_chain[k+1] = lim_chain[k] & at_lim[k];

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load_i     (dig_load),
            .load_val_i (dig_val[k*BCD_W +: BCD_W]),
            .en_i       (step_en & lim_chain[k]),
            .up_i       (up),
            .digit_o    (count[k*BCD_W +: BCD_W]),
            .at_limit_o (at_lim[k])
        );
    end

    assign tc = running_q && tick && lim_chain[DIGITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            reload_q  <= '0;
        end else if (load) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= !data_ok;
            reload_q  <= load_data;
        end else if (stop) begin
            if (state_q == RUN) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
            end
        end else if (start && (state_q != RUN)) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else if (act_tick && tc && !AUTO_RELOAD) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised multi-digit BCD up/down timer built from a chain of single-digit BCD counters with carry/borrow propagation. It adds a run/pause/done state machine, optional auto-reload, an input-validity error flag and a cascade terminal-count output. It sits between a prescaled tick source and the seven-segment display driver. Typical uses are countdown timers, stopwatch digits and event counters.

## Interface

Parameters:
- DIGITS, default 4: number of BCD digits; must be ≥1.
- AUTO_RELOAD, default 0: 1 = on terminal count, reload the last loaded value and keep running; 0 = stop in DONE.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- load, input, 1: load `data` into count and reload register.
- data, input, 4*DIGITS: BCD load value; digit 0 is in bits [3:0].
- start, input, 1: begin or resume counting.
- stop, input, 1: pause counting.
- tick, input, 1: count enable, one step per cycle when high.
- up, input, 1: direction; 1 = increment, 0 = decrement.
- count, output, 4*DIGITS: current BCD value, registered.
- running, output, 1: high when state is RUN, registered.
- done, output, 1: high when state is DONE, registered.
- tc, output, 1: combinational terminal-count strobe for cascading.
- err, output, 1: sticky flag for an invalid BCD load, registered.

## Operation

- States are IDLE, RUN and DONE.
- Terminal value is all digits 0 when counting down and all digits 9 when counting up.
- tc = running && tick && (count == terminal for current `up`).
- Input priority per cycle: reset > load > stop > start > tick.
- reset:
  - count = 0, reload register = 0.
  - State goes to IDLE; running, done and err go to 0.
- load, in any state:
  - If every digit of `data` is ≤9: count and reload register take `data`, err = 0.
  - If any digit is >9: count and reload register take 0, err = 1.
  - In both cases the state goes to IDLE.
- start:
  - IDLE → RUN.
  - DONE → RUN, with count reloaded from the reload register.
  - Ignored in RUN.
- stop: RUN → IDLE with count held. A later start resumes from the held value.
- In RUN, tick with tc = 0: BCD step.
  - Digit 0 always steps.
  - Digit k steps only when all lower digits are at 0 (down) or 9 (up).
  - Down: 0 wraps to 9. Up: 9 wraps to 0.
- In RUN, tick with tc = 1:
  - AUTO_RELOAD = 1: count takes the reload register and the state stays RUN.
  - AUTO_RELOAD = 0: count is held at the terminal value and the state goes to DONE.
- tick outside RUN is ignored.
- `up` may change at any time. It is sampled on each tick.
- Start with count already at terminal: the first tick produces tc.

## Timing

- All state and count updates occur on the rising edge of clk.
- Latencies:
  - `running` rises 1 cycle after start.
  - A tick in the same cycle as start is ignored.
  - count reflects a tick 1 cycle later.
  - `tc` is combinational in the tick cycle.
  - `done` rises 1 cycle after tc when AUTO_RELOAD = 0.
- Simultaneous inputs:
  - load + tick: load wins, no step.
  - stop + tick in RUN: stop wins, no step.
  - reset mid-run: all outputs return to their reset values on the next edge.

## Structure

- Package bcd_timer_pkg holds:
  - state enum: IDLE, RUN, DONE.
  - BCD_W = 4.
  - BCD_MAX = 4'd9.
  - function bcd_valid(digit).
- Sub-module bcd_digit:
  - One registered digit with load, en, up, and sync reset.
  - Outputs: digit and at_limit (0 when down, 9 when up).
  - Instantiated DIGITS times in a generate loop.
  - Each digit's en is tick-qualified and ANDed with the at_limit outputs of all lower digits.
- The top level holds the FSM, the reload register, err, and tc.

## Test plan

All scenarios use DIGITS = 4.

- Load 0x0012 (valid BCD), start, 12 ticks with up = 0:
  - count steps 0012 → 0011 → … → 0000.
  - The next tick gives tc = 1 that cycle, then done = 1 and count stays 0000.
- Load 0x0100, up = 0, one tick → count 0099. Load 0x0999, up = 1, one tick → count 1000.
- With AUTO_RELOAD = 1: load 0x0003, start, 4 ticks:
  - count goes 0002, 0001, 0000.
  - The 4th tick gives tc = 1 and count returns to 0003; running stays 1.
- Load 0x00A5 → count 0000, err = 1. Then load 0x0042 → count 0042, err = 0.
- Simultaneous inputs:
  - Start and tick in the same cycle → no step.
  - Stop with tick in RUN → count held, running = 0.
  - Start again → counting resumes from the held value.
- Reset asserted mid-count (count 0057, running): the next edge gives count 0000 and running, done, err all 0.
